// File: rtl/vexec_seq.sv
// ---------------------------------------------------------------------------
// vexec_seq -- multi-cycle vector ALU sequencer for the execute stage.
//
// A vector operation present in execute (start_E) is captured and then
// processed one N-bit lane per cycle. The pipeline is stalled while lanes are
// being produced, and a one-cycle done_M pulse marks the completed result.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-low reset
//   flush_E    in   synchronous abort from the hazard unit (beats start_E)
//   start_E    in   vector ALU operation present in execute
//   ALUctrl_E  in   [L-1:0] operation select
//   regScr_E   in   [M-1:0] destination register index
//   regVA_E    in   [V-1:0] operand A
//   regVB_E    in   [V-1:0] operand B
//   stall_E    out  hold fetch, decode and the decode-execute register
//   done_M     out  one-cycle result-valid pulse
//   regScr_M   out  [M-1:0] captured destination index
//   resV_M     out  [V-1:0] vector result
//
// Optional feature: define VEXEC_SAT_EN to make ALUctrl 000/001 perform
// signed saturating add/sub per lane instead of wrapping arithmetic.
// ---------------------------------------------------------------------------
module vexec_seq #(
  parameter int V = 128,
  parameter int N = 32,
  parameter int M = 4,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_E,
  input  logic         start_E,
  input  logic [L-1:0] ALUctrl_E,
  input  logic [M-1:0] regScr_E,
  input  logic [V-1:0] regVA_E,
  input  logic [V-1:0] regVB_E,
  output logic         stall_E,
  output logic         done_M,
  output logic [M-1:0] regScr_M,
  output logic [V-1:0] resV_M
);

  localparam int LANES = V / N;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [V-1:0]   a_q;
  logic [V-1:0]   b_q;
  logic [L-1:0]   ctrl_q;
  logic           done_q;
  logic [M-1:0]   scr_q;
  logic [V-1:0]   res_q;
  logic [N-1:0]   lane_a_s;
  logic [N-1:0]   lane_b_s;
  logic [N-1:0]   lane_res_d;

  // One lane of the vector ALU; all arithmetic is modulo 2^N unless the
  // saturating variant is built in.
  function automatic logic [N-1:0] lane_alu(input logic [2:0]   op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-1:0] dif;
    logic [N-1:0] res;
    sum = a + b;
    dif = a - b;
    case (op)
      3'b000: begin
`ifdef VEXEC_SAT_EN
        // Overflow only when both operands share a sign the sum lacks.
        if ((a[N-1] == b[N-1]) && (sum[N-1] != a[N-1])) begin
          res = a[N-1] ? SMIN : SMAX;
        end else begin
          res = sum;
        end
`else
        res = sum;
`endif
      end
      3'b001: begin
`ifdef VEXEC_SAT_EN
        // Overflow only when operand signs differ and the result flips A's sign.
        if ((a[N-1] != b[N-1]) && (dif[N-1] != a[N-1])) begin
          res = a[N-1] ? SMIN : SMAX;
        end else begin
          res = dif;
        end
`else
        res = dif;
`endif
      end
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = a ^ b;
      3'b101:  res = a << b[4:0];
      3'b110:  res = a >> b[4:0];
      3'b111:  res = a;
      default: res = a;
    endcase
    return res;
  endfunction

  // Select the current lane of the captured operands and compute its result.
  always_comb begin
    lane_a_s   = a_q[cnt_q*N +: N];
    lane_b_s   = b_q[cnt_q*N +: N];
    lane_res_d = lane_alu(ctrl_q[2:0], lane_a_s, lane_b_s);
  end

  // Sequencer FSM with registered result, index and done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      done_q  <= 1'b0;
      scr_q   <= '0;
      res_q   <= '0;
    end else if (flush_E) begin
      // Abort whatever is in flight; result registers keep their contents.
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_E) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            a_q     <= regVA_E;
            b_q     <= regVB_E;
            ctrl_q  <= ALUctrl_E;
            scr_q   <= regScr_E;
            res_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          res_q[cnt_q*N +: N] <= lane_res_d;
          if (cnt_q == CW'(LANES - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
            done_q  <= 1'b0;
          end
        end
        DONE: begin
          // start_E is still the held instruction here; never re-issue it.
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stall must assert in the very cycle a new operation is presented.
  assign stall_E  = (state_q == BUSY) | ((state_q == IDLE) & start_E & ~flush_E);
  assign done_M   = done_q;
  assign regScr_M = scr_q;
  assign resV_M   = res_q;

endmodule

// File: tb/tb_vexec_seq.sv
// Directed-vector bench for vexec_seq (default parameters).
module tb_vexec_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_E;
  logic         start_E;
  logic [2:0]   ALUctrl_E;
  logic [3:0]   regScr_E;
  logic [127:0] regVA_E;
  logic [127:0] regVB_E;
  logic         stall_E;
  logic         done_M;
  logic [3:0]   regScr_M;
  logic [127:0] resV_M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_last = 0;
  int done_prev = 0;

  vexec_seq dut (
    .clk(clk), .rst(rst), .flush_E(flush_E), .start_E(start_E),
    .ALUctrl_E(ALUctrl_E), .regScr_E(regScr_E), .regVA_E(regVA_E),
    .regVB_E(regVB_E), .stall_E(stall_E), .done_M(done_M),
    .regScr_M(regScr_M), .resV_M(resV_M)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every done pulse and the cycle it appeared in.
  always @(negedge clk) begin
    if (done_M === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      done_prev <= done_last;
      done_last <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation at the current cycle t (IDLE), hold it like a stalled
  // pipeline would through DONE, and check stall/done timing and the result.
  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [127:0] a,
                        input logic [127:0] b, input logic [3:0] scr, input logic [127:0] exp);
    start_E = 1'b1; ALUctrl_E = ctrl; regVA_E = a; regVB_E = b; regScr_E = scr;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk({tag, "_stall"}, {127'd0, stall_E}, 128'd1);
      chk({tag, "_nodone"}, {127'd0, done_M}, 128'd0);
      tick();
    end
    #1;
    chk({tag, "_done"}, {127'd0, done_M}, 128'd1);
    chk({tag, "_stall_done"}, {127'd0, stall_E}, 128'd0);
    chk({tag, "_res"}, resV_M, exp);
    chk({tag, "_scr"}, {124'd0, regScr_M}, {124'd0, scr});
    tick();
    start_E = 1'b0;
  endtask

  logic [127:0] exp_sat_add;
  logic [127:0] exp_sat_sub;
  int n0;

  initial begin
    rst = 1'b0; flush_E = 1'b0; start_E = 1'b0; ALUctrl_E = 3'd0;
    regScr_E = 4'd0; regVA_E = 128'd0; regVB_E = 128'd0;

    // Reset for two cycles.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_stall", {127'd0, stall_E}, 128'd0);
    chk("rst_done", {127'd0, done_M}, 128'd0);
    chk("rst_scr", {124'd0, regScr_M}, 128'd0);
    chk("rst_res", resV_M, 128'd0);
    tick();

    // Basic add.
    run_op("add", 3'b000, pack4(32'd1, 32'd2, 32'd3, 32'd4),
           pack4(32'd10, 32'd20, 32'd30, 32'd40), 4'd3,
           pack4(32'd11, 32'd22, 32'd33, 32'd44));
    #1;
    chk("add_done_gone", {127'd0, done_M}, 128'd0);
    chk("add_res_hold", resV_M, pack4(32'd11, 32'd22, 32'd33, 32'd44));
    tick();

    // Overflowing add / sub: wrap or saturate depending on build.
`ifdef VEXEC_SAT_EN
    exp_sat_add = pack4(32'h7FFFFFFF, 32'h80000000, 32'd5, 32'd0);
    exp_sat_sub = pack4(32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE);
`else
    exp_sat_add = pack4(32'h80000000, 32'h7FFFFFFF, 32'd5, 32'd0);
    exp_sat_sub = pack4(32'd7, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
`endif
    run_op("add_ovf", 3'b000, pack4(32'h7FFFFFFF, 32'h80000000, 32'd2, 32'hFFFFFFFF),
           pack4(32'd1, 32'hFFFFFFFF, 32'd3, 32'd1), 4'd5, exp_sat_add);
    run_op("sub", 3'b001, pack4(32'd10, 32'h80000000, 32'd0, 32'd5),
           pack4(32'd3, 32'd1, 32'd1, 32'd7), 4'd6, exp_sat_sub);

    // Logic operations and pass-through.
    run_op("and", 3'b010, pack4(32'hF0F0F0F0, 32'd0, 32'hFFFFFFFF, 32'h12345678),
           pack4(32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 32'd0), 4'd1,
           pack4(32'd0, 32'd0, 32'hFFFFFFFF, 32'd0));
    run_op("or", 3'b011, pack4(32'hF0F0F0F0, 32'd0, 32'hFFFFFFFF, 32'h12345678),
           pack4(32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 32'd0), 4'd2,
           pack4(32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'h12345678));
    run_op("xor", 3'b100, pack4(32'hF0F0F0F0, 32'd0, 32'hFFFFFFFF, 32'h12345678),
           pack4(32'h0F0F0F0F, 32'd0, 32'hFFFFFFFF, 32'd0), 4'd4,
           pack4(32'hFFFFFFFF, 32'd0, 32'd0, 32'h12345678));
    run_op("pass", 3'b111, pack4(32'd9, 32'd8, 32'd7, 32'd6),
           pack4(32'hDEADBEEF, 32'd1, 32'd2, 32'd3), 4'd7,
           pack4(32'd9, 32'd8, 32'd7, 32'd6));
    tick();

    // Back-to-back shifts: second op presented in the single IDLE cycle.
    run_op("shl", 3'b101, pack4(32'd1, 32'h80000001, 32'd3, 32'hFFFFFFFF),
           pack4(32'h24, 32'd1, 32'd31, 32'd0), 4'd8,
           pack4(32'd16, 32'd2, 32'h80000000, 32'hFFFFFFFF));
    run_op("shr", 3'b110, pack4(32'h100, 32'h80000000, 32'hF, 32'hFFFFFFFF),
           pack4(32'd4, 32'd4, 32'd4, 32'd4), 4'd9,
           pack4(32'h10, 32'h08000000, 32'd0, 32'h0FFFFFFF));
    chk("b2b_gap", 128'(done_last - done_prev), 128'd6);

    // Flush wins over start in IDLE.
    start_E = 1'b1; flush_E = 1'b1; ALUctrl_E = 3'b000;
    #1;
    chk("flush_idle_stall", {127'd0, stall_E}, 128'd0);
    tick();
    start_E = 1'b0; flush_E = 1'b0;
    #1;
    chk("flush_idle_nostart", {127'd0, stall_E}, 128'd0);
    tick();

    // Flush in the 2nd BUSY cycle.
    n0 = done_cnt;
    start_E = 1'b1; ALUctrl_E = 3'b000; regScr_E = 4'd2;
    regVA_E = pack4(32'd5, 32'd5, 32'd5, 32'd5); regVB_E = pack4(32'd1, 32'd1, 32'd1, 32'd1);
    tick();            // BUSY 1
    tick();            // BUSY 2
    flush_E = 1'b1; start_E = 1'b0;
    #1;
    chk("flush_busy_stall", {127'd0, stall_E}, 128'd1);
    tick();
    flush_E = 1'b0;
    #1;
    chk("flush_after_stall", {127'd0, stall_E}, 128'd0);
    chk("flush_after_done", {127'd0, done_M}, 128'd0);
    repeat (6) tick();
    chk("flush_no_done", 128'(done_cnt - n0), 128'd0);

    // Lane counter must restart from lane 0 after the flush.
    run_op("add_post_flush", 3'b000, pack4(32'd1, 32'd2, 32'd3, 32'd4),
           pack4(32'd100, 32'd200, 32'd300, 32'd400), 4'hC,
           pack4(32'd101, 32'd202, 32'd303, 32'd404));
    tick();

    // Reset in the 3rd BUSY cycle.
    n0 = done_cnt;
    start_E = 1'b1; ALUctrl_E = 3'b011; regScr_E = 4'hA;
    regVA_E = pack4(32'h11, 32'h22, 32'h33, 32'h44); regVB_E = pack4(32'h100, 32'h200, 32'h300, 32'h400);
    tick();            // BUSY 1
    tick();            // BUSY 2
    tick();            // BUSY 3
    start_E = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_stall", {127'd0, stall_E}, 128'd0);
    chk("rstmid_done", {127'd0, done_M}, 128'd0);
    chk("rstmid_scr", {124'd0, regScr_M}, 128'd0);
    chk("rstmid_res", resV_M, 128'd0);
    repeat (6) tick();
    chk("rstmid_no_done", 128'(done_cnt - n0), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
